// File: rtl/o_reg_drain_pkg.sv
// rtl/o_reg_drain_pkg.sv - shared state encoding and width helpers for the o_reg drain path
package o_reg_drain_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_STREAM = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   function automatic int word_width(input int f_width, input int i_width);
      return f_width + i_width;
   endfunction

   // A single-row column still needs a one-bit index port.
   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/o_reg_drain.sv
// rtl/o_reg_drain.sv - snapshots a column of o_reg words, clears them, streams them out
module o_reg_drain
   import o_reg_drain_pkg::*;
#(
   parameter int F_WIDTH          = 8,
   parameter int I_WIDTH          = 8,
   parameter int N_ROWS           = 4,
   parameter int CLEAR_ON_CAPTURE = 1,
   localparam int W               = word_width(F_WIDTH, I_WIDTH),
   localparam int IW              = idx_width(N_ROWS)
) (
   input  logic                clk_i,
   input  logic                drain_rst_i,
   input  logic                start_i,
   input  logic [N_ROWS*W-1:0] oreg_data_i,
   output logic                oreg_rst_o,
   output logic                busy_o,
   output logic                done_o,
   output logic [W-1:0]        out_data_o,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic                out_last_o,
   output logic [IW-1:0]       out_idx_o
);

   localparam logic [IW-1:0] LAST_IDX = IW'(N_ROWS - 1);

   logic [1:0]    state;
   logic [IW-1:0] idx;
   logic [W-1:0]  shadow [N_ROWS];
   logic          is_last;

   assign is_last = (idx == LAST_IDX);

   always_ff @(posedge clk_i) begin
      if (drain_rst_i) begin
         state       <= ST_IDLE;
         idx         <= '0;
         out_valid_o <= 1'b0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         oreg_rst_o  <= 1'b0;
         for (int r = 0; r < N_ROWS; r++) begin
            shadow[r] <= '0;
         end
      end else begin
         oreg_rst_o <= 1'b0;
         done_o     <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start_i) begin
                  // The clear pulse lands after this edge, so the snapshot always precedes it.
                  for (int r = 0; r < N_ROWS; r++) begin
                     shadow[r] <= oreg_data_i[r*W +: W];
                  end
                  idx         <= '0;
                  state       <= ST_STREAM;
                  out_valid_o <= 1'b1;
                  busy_o      <= 1'b1;
                  oreg_rst_o  <= (CLEAR_ON_CAPTURE != 0);
               end
            end
            ST_STREAM: begin
               if (out_valid_o && out_ready_i) begin
                  if (is_last) begin
                     out_valid_o <= 1'b0;
                     busy_o      <= 1'b0;
                     done_o      <= 1'b1;
                     state       <= ST_DONE;
                  end else begin
                     idx <= idx + IW'(1);
                  end
               end
            end
            ST_DONE: begin
               busy_o <= 1'b0;
               state  <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Outputs come only from registered state, idx and shadow; out_ready_i never reaches them.
   assign out_data_o = (state == ST_STREAM) ? shadow[idx] : '0;
   assign out_last_o = (state == ST_STREAM) && is_last;
   assign out_idx_o  = idx;

endmodule

// File: tb/tb_o_reg_drain.sv
// tb/tb_o_reg_drain.sv - scoreboard bench for o_reg_drain in 4-row, no-clear and 1-row builds
module tb_o_reg_drain;

   typedef struct packed {
      logic [15:0] d;
      logic [1:0]  i;
      logic        l;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, start2;
   logic [63:0] data;
   logic [15:0] data2;
   logic        ready, ready2;

   logic        orst0, busy0, done0, v0, l0;
   logic [15:0] d0;
   logic [1:0]  i0;
   logic        orst1, busy1, done1, v1, l1;
   logic [15:0] d1;
   logic [1:0]  i1;
   logic        orst2, busy2, done2, v2, l2;
   logic [15:0] d2;
   logic        i2;

   int   errors = 0;
   int   checks = 0;
   int   done0_cnt = 0, rst0_cnt = 0, rst1_cnt = 0, done2_cnt = 0;
   exp_t q0[$];
   logic [15:0] q2[$];
   exp_t mon_e;
   int   lat;

   always #5 clk = ~clk;

   o_reg_drain #(.F_WIDTH(8), .I_WIDTH(8), .N_ROWS(4), .CLEAR_ON_CAPTURE(1)) dut0 (
      .clk_i(clk), .drain_rst_i(rst), .start_i(start), .oreg_data_i(data),
      .oreg_rst_o(orst0), .busy_o(busy0), .done_o(done0), .out_data_o(d0),
      .out_valid_o(v0), .out_ready_i(ready), .out_last_o(l0), .out_idx_o(i0));

   o_reg_drain #(.F_WIDTH(8), .I_WIDTH(8), .N_ROWS(4), .CLEAR_ON_CAPTURE(0)) dut1 (
      .clk_i(clk), .drain_rst_i(rst), .start_i(start), .oreg_data_i(data),
      .oreg_rst_o(orst1), .busy_o(busy1), .done_o(done1), .out_data_o(d1),
      .out_valid_o(v1), .out_ready_i(ready), .out_last_o(l1), .out_idx_o(i1));

   o_reg_drain #(.F_WIDTH(8), .I_WIDTH(8), .N_ROWS(1), .CLEAR_ON_CAPTURE(1)) dut2 (
      .clk_i(clk), .drain_rst_i(rst), .start_i(start2), .oreg_data_i(data2),
      .oreg_rst_o(orst2), .busy_o(busy2), .done_o(done2), .out_data_o(d2),
      .out_valid_o(v2), .out_ready_i(ready2), .out_last_o(l2), .out_idx_o(i2));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push4(input logic [15:0] r0, input logic [15:0] r1,
                        input logic [15:0] r2, input logic [15:0] r3);
      q0.push_back('{d: r0, i: 2'd0, l: 1'b0});
      q0.push_back('{d: r1, i: 2'd1, l: 1'b0});
      q0.push_back('{d: r2, i: 2'd2, l: 1'b0});
      q0.push_back('{d: r3, i: 2'd3, l: 1'b1});
      data = {r3, r2, r1, r0};
   endtask

   task automatic clr_counts();
      done0_cnt = 0; rst0_cnt = 0; done2_cnt = 0;
   endtask

   // Pulse start for one edge and check the cycle that follows it.
   task automatic kick(input logic hold);
      start = 1'b1;
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
      chk("first_valid", v0, 1);
      chk("first_busy", busy0, 1);
      chk("clear_pulse", orst0, 1);
      chk("no_clear_dut1", orst1, 0);
      chk("first_idx", i0, 0);
   endtask

   task automatic wait_done(input int maxc, output int l);
      l = -1;
      for (int k = 1; k <= maxc; k++) begin
         @(posedge clk); #1;
         if (done0) begin
            l = k;
            break;
         end
      end
      if (l < 0) begin
         checks++; errors++;
         $display("FAIL done_timeout: got none expected within %0d cycles", maxc);
      end
   endtask

   // Scoreboard monitor: every presented word is compared to the queue head; pop on handshake.
   always @(negedge clk) begin
      if (!rst) begin
         if (orst0) rst0_cnt++;
         if (orst1) rst1_cnt++;
         if (done0) done0_cnt++;
         if (done2) done2_cnt++;
         if (v0) begin
            if (q0.size() == 0) begin
               checks++; errors++;
               $display("FAIL extra_word: got 0x%0h expected no word", d0);
            end else begin
               mon_e = q0[0];
               chk("data", d0, mon_e.d);
               chk("idx", i0, mon_e.i);
               chk("last", l0, mon_e.l);
               chk("data_dut1", d1, mon_e.d);
               chk("valid_dut1", v1, 1);
               chk("last_dut1", l1, mon_e.l);
               if (ready) void'(q0.pop_front());
            end
         end
         if (v2) begin
            if (q2.size() == 0) begin
               checks++; errors++;
               $display("FAIL extra_word_n1: got 0x%0h expected no word", d2);
            end else begin
               chk("data_n1", d2, q2[0]);
               chk("idx_n1", i2, 0);
               chk("last_n1", l2, 1);
               if (ready2) void'(q2.pop_front());
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; start2 = 1'b0; data = '0; data2 = '0;
      ready = 1'b1; ready2 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", v0, 0);
      chk("rst_busy", busy0, 0);
      chk("rst_done", done0, 0);
      chk("rst_clear", orst0, 0);
      chk("rst_data", d0, 0);
      chk("rst_idx", i0, 0);
      chk("rst_last", l0, 0);
      chk("rst_last_n1", l2, 0);
      chk("rst_valid_n1", v2, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Basic stream, ready held high
      clr_counts();
      push4(16'h0102, 16'hFFFE, 16'h7FFF, 16'h8000);
      kick(1'b0);
      wait_done(20, lat);
      chk("basic_done_lat", lat, 4);
      chk("basic_busy_done", busy0, 0);
      @(posedge clk); #1;
      chk("basic_done_once", done0_cnt, 1);
      chk("basic_clear_once", rst0_cnt, 1);
      chk("basic_drained", q0.size(), 0);

      // Back-pressure with ready pattern 1,0,0,1,1,0,1
      clr_counts();
      push4(16'h0102, 16'hFFFE, 16'h7FFF, 16'h8000);
      ready = 1'b1;
      kick(1'b0);
      begin
         logic [6:0] pat;
         pat = 7'b1011001;
         for (int k = 1; k < 7; k++) begin
            @(posedge clk); #1;
            ready = pat[k];
         end
      end
      ready = 1'b1;
      wait_done(20, lat);
      chk("bp_done_lat", lat, 1);
      @(posedge clk); #1;
      chk("bp_done_once", done0_cnt, 1);
      chk("bp_drained", q0.size(), 0);

      // Snapshot isolation: inputs change right after capture
      clr_counts();
      push4(16'h0A0B, 16'hC0DE, 16'h0001, 16'hFFFF);
      kick(1'b0);
      data = {4{16'h1111}};
      wait_done(20, lat);
      chk("snap_done_lat", lat, 4);
      @(posedge clk); #1;
      chk("snap_drained", q0.size(), 0);

      // start held through STREAM and the DONE cycle
      clr_counts();
      push4(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
      kick(1'b1);
      data = {4{16'h0F0F}};
      wait_done(20, lat);
      chk("ign_done_lat", lat, 4);
      @(posedge clk); #1;
      start = 1'b0;
      chk("ign_no_recapture", v0, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("ign_done_once", done0_cnt, 1);
      chk("ign_clear_once", rst0_cnt, 1);
      chk("ign_drained", q0.size(), 0);

      // Reset mid-stream at idx 2, then a fresh run
      clr_counts();
      push4(16'h2222, 16'h3333, 16'h4444, 16'h5555);
      kick(1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("mid_idx", i0, 2);
      rst = 1'b1;
      q0.delete();
      @(posedge clk); #1;
      chk("mid_rst_valid", v0, 0);
      chk("mid_rst_busy", busy0, 0);
      chk("mid_rst_done", done0, 0);
      chk("mid_rst_data", d0, 0);
      chk("mid_rst_idx", i0, 0);
      chk("mid_rst_last", l0, 0);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("mid_no_done", done0_cnt, 0);
      push4(16'h6666, 16'h7777, 16'h8888, 16'h9999);
      kick(1'b0);
      wait_done(20, lat);
      chk("mid_fresh_lat", lat, 4);
      @(posedge clk); #1;
      chk("mid_fresh_drained", q0.size(), 0);

      // Single-row build
      q2.push_back(16'hABCD);
      data2 = 16'hABCD;
      start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      chk("n1_valid", v2, 1);
      chk("n1_clear", orst2, 1);
      @(posedge clk); #1;
      chk("n1_done", done2, 1);
      chk("n1_valid_off", v2, 0);
      @(posedge clk); #1;
      chk("n1_done_once", done2_cnt, 1);
      chk("n1_drained", q2.size(), 0);

      chk("dut1_never_clears", rst1_cnt, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
